// File: rtl/dsp_seq_if.sv
// Sequencer bus: job request, operand stream, DSP cell controls and result port.
// The slave modport is the sequencer side; master is the feeder/cell/consumer side.
interface dsp_seq_if #(
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic                    op_valid;
    logic                    op_ready;
    logic signed [15:0]      op_a;
    logic signed [15:0]      op_b;
    logic signed [15:0]      a_value;
    logic signed [15:0]      b_value;
    logic                    aen;
    logic                    ben;
    logic                    men;
    logic                    sen;
    logic                    sreset;
    logic                    sat;
    logic signed [15:0]      s_out;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [15:0]      res_data;
    logic                    res_sat;

    modport slave (
        input  start, len, op_valid, op_a, op_b, sat, s_out, res_ready,
        output busy, op_ready, a_value, b_value, aen, ben, men, sen, sreset,
               res_valid, res_data, res_sat
    );

    modport master (
        output start, len, op_valid, op_a, op_b, sat, s_out, res_ready,
        input  busy, op_ready, a_value, b_value, aen, ben, men, sen, sreset,
               res_valid, res_data, res_sat
    );
endinterface

// File: rtl/dsp_seq.sv
// Job sequencer for one systolic DSP MAC cell: streams len operand pairs into the
// cell, waits for the enable pipeline to drain, latches and returns the result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; len latched on start
// FEED    | accepting operand pairs until len have been taken
// DRAIN   | waiting for aen/men pipeline to empty (last sen in flight)
// LATCH   | sreset pulse: DSP moves accumulator to s_out and clears it
// CAPTURE | s_out/sat registered into res_data/res_sat
// OUT     | res_valid held until res_ready
module dsp_seq #(
    parameter int LEN_W = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    dsp_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_LATCH,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_aen;
    logic               r_men;
    logic               r_sen;
    logic signed [15:0] r_a;
    logic signed [15:0] r_b;
    logic signed [15:0] r_res_data;
    logic               r_res_sat;

    logic w_busy;
    logic w_op_ready;
    logic w_sreset;
    logic w_res_valid;
    logic w_hs;
    logic w_last;

    assign w_hs   = w_op_ready & bus.op_valid;
    assign w_last = (r_cnt == (r_len - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b1;
        w_op_ready  = 1'b0;
        w_sreset    = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = (bus.len == '0) ? S_LATCH : S_FEED;
                end
            end
            S_FEED: begin
                w_op_ready = 1'b1;
                if (w_hs && w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // last sen is in flight once aen and men are both clear
                if (!r_aen && !r_men) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_sreset = 1'b1;
                w_next   = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_aen      <= 1'b0;
            r_men      <= 1'b0;
            r_sen      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_res_data <= '0;
            r_res_sat  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_len <= bus.len;
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            r_aen <= w_hs;
            r_men <= r_aen;
            r_sen <= r_men;
            if (w_hs) begin
                r_a <= bus.op_a;
                r_b <= bus.op_b;
            end
            if (r_state == S_CAPTURE) begin
                r_res_data <= bus.s_out;
                r_res_sat  <= bus.sat;
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.op_ready  = w_op_ready;
    assign bus.a_value   = r_a;
    assign bus.b_value   = r_b;
    assign bus.aen       = r_aen;
    assign bus.ben       = r_aen;
    assign bus.men       = r_men;
    assign bus.sen       = r_sen;
    assign bus.sreset    = w_sreset;
    assign bus.res_valid = w_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_sat   = r_res_sat;
endmodule

// File: doc/dsp_seq.md
# dsp_seq

Sequencer for one systolic-array DSP MAC cell. It accepts a dot-product job of `len` operand pairs and streams them into the cell by driving the operand, enable and clear controls. It then harvests the 16-bit saturated result and saturation flag and returns them on a valid/ready result port. It sits between the array's operand feeder and the DSP cell, on the driving side of the cell's control interface.

## Interface
- `LEN_W`, default 8: width of the job length.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: number of operand pairs; sampled with `start`.
- `busy` out 1: high whenever state != IDLE.
- `op_valid` in 1: operand pair available.
- `op_ready` out 1: sequencer accepts operand pair.
- `op_a`, `op_b` in 16 (signed): operand pair.
- `a_value`, `b_value` out 16 (signed): operands to the DSP cell.
- `aen`, `ben` out 1: DSP operand-register load enables (always equal).
- `men` out 1: DSP product-register enable.
- `sen` out 1: DSP accumulate enable.
- `sreset` out 1: DSP result-latch and accumulator-clear pulse.
- `sat` in 1: DSP saturation flag.
- `s_out` in 16 (signed): DSP result.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_data` out 16 (signed): captured dot-product result.
- `res_sat` out 1: captured saturation flag.

## Operation
- States:
  - IDLE -> FEED on `start` (`len`!=0), or IDLE -> LATCH on `start` (`len`==0).
  - FEED -> DRAIN when the accepted count reaches `len`.
  - DRAIN -> LATCH when the product pipeline is empty.
  - LATCH -> CAPTURE -> OUT, unconditionally.
  - OUT -> IDLE on `res_valid & res_ready`.
- `start` while busy is ignored. `len` is latched at start.
- FEED:
  - `op_ready`=1 while accepted count < len.
  - Each handshake (`op_valid & op_ready`) increments the count.
  - The cycle after a handshake, `aen`=`ben`=1 with `a_value`/`b_value` = that pair.
  - `a_value`/`b_value` hold their last value when `aen`=0.
- Enable pipeline:
  - `men` = `aen` delayed 1 cycle; `sen` = `men` delayed 1 cycle.
  - Bubbles in `op_valid` produce matching gaps in `aen`/`men`/`sen`. Exactly `len` pulses of each are issued per job.
- LATCH: `sreset`=1 for exactly one cycle. This moves the DSP result to `s_out`/`sat` and clears its accumulator, leaving the cell clean for the next job.
- CAPTURE: registers `s_out` -> `res_data` and `sat` -> `res_sat`.
- OUT:
  - `res_valid`=1; `res_data`/`res_sat` held stable until accepted.
  - `op_ready`=0.
  - No DSP enables are asserted.
- `len`=0: no operand accepted; result is 0, sat 0. The DSP accumulator is zero after reset or any previous `sreset`.
- Arithmetic is entirely in the DSP cell. The sequencer passes operands unmodified and performs no width conversion.
- Reset, including mid-job:
  - All outputs go to 0: `busy`, `op_ready`, `aen`, `ben`, `men`, `sen`, `sreset`, `res_valid`, `res_data`, `res_sat`, `a_value`, `b_value`.
  - State returns to IDLE and the count clears.
  - A job in flight is discarded; the DSP cell shares `rst_n`.

## Timing
- Start accepted in cycle S -> `busy`=1 and `op_ready`=1 (`len`>0) from S+1.
- Final operand handshake in cycle L produces:
  - `aen`/`ben` at L+1, `men` at L+2, `sen` at L+3.
  - `sreset` at L+4; `s_out` valid at L+5 (CAPTURE).
  - `res_valid` from L+6.
- `len`=0: `sreset` at S+1, CAPTURE at S+2, `res_valid` from S+3.
- `sreset` is issued one cycle after the final `sen`, never concurrent with it.
- Result accepted in cycle R -> IDLE at R+1, `busy`=0 at R+1. A new `start` is sampled from R+1.
- Minimum job period: len + 7 cycles with continuous `op_valid` and `res_ready`.

## Test plan
- **Basic dot product:** len=3, a=(1,2,3), b=(4,5,6), `op_valid` continuous, `res_ready`=1 -> `aen` pulses at S+2..S+4, `sreset` at S+7, `res_valid` at S+9, `res_data`=32, `res_sat`=0.
- **Bubbles:** same job with `op_valid` toggling every other cycle -> exactly 3 `men` and 3 `sen` pulses, each `sen` 2 cycles after its `aen`, `res_data`=32, `sreset` 4 cycles after the last handshake.
- **Zero length:** len=0 -> no `op_ready`, no `aen`/`men`/`sen`, `sreset` at S+1, `res_valid` at S+3, `res_data`=0, `res_sat`=0.
- **Saturation:** len=2, a=(200,200), b=(200,200) -> `res_data`=0x7FFF, `res_sat`=1. A following job len=1, a=2, b=3 -> `res_data`=6, `res_sat`=0, confirming the accumulator was cleared.
- **Backpressure:** `res_ready`=0 for 5 cycles after `res_valid` -> `res_valid`, `res_data` and `res_sat` stable; `op_ready`=0; a `start` pulse during the hold is ignored; IDLE the cycle after `res_ready`=1.
- **Reset mid-operation:** `rst_n` low after the first handshake of a len=4 job -> all outputs 0, `busy`=0. Then len=1, a=-3, b=7 -> `res_data`=0xFFEB (-21), `res_sat`=0.
